// File: rtl/ctrl_pipeline_pkg.sv
// Shared definitions for the control pipeline: control-bundle layout, bubble value
// and the default register-address width.
package ctrl_pipeline_pkg;

    localparam int REG_AW_DEFAULT = 5;

    // Control bundle layout, LSB first
    localparam int CTRL_W       = 8;
    localparam int ALUOP_LSB    = 0;
    localparam int ALUOP_MSB    = 1;
    localparam int ALUSRC_BIT   = 2;
    localparam int BRANCH_BIT   = 3;
    localparam int MEMREAD_BIT  = 4;
    localparam int MEMWRITE_BIT = 5;
    localparam int MEMTOREG_BIT = 6;
    localparam int REGWRITE_BIT = 7;

    localparam logic [CTRL_W-1:0] BUBBLE = '0;

    // MemtoReg is meaningless without MemRead; masking it also keeps an
    // undriven decoder output from propagating down the pipe.
    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic [1:0] alu_op,
        input logic       alu_src,
        input logic       branch,
        input logic       mem_read,
        input logic       mem_write,
        input logic       mem_to_reg,
        input logic       reg_write
    );
        logic [CTRL_W-1:0] c;
        c                         = BUBBLE;
        c[ALUOP_MSB:ALUOP_LSB]    = alu_op;
        c[ALUSRC_BIT]             = alu_src;
        c[BRANCH_BIT]             = branch;
        c[MEMREAD_BIT]            = mem_read;
        c[MEMWRITE_BIT]           = mem_write;
        c[MEMTOREG_BIT]           = mem_to_reg & mem_read;
        c[REGWRITE_BIT]           = reg_write;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard_detect.sv
// Combinational load-use and taken-branch detection for the ID/EX boundary.
module hazard_detect
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_ALUSrc,
    input  logic              id_MemWrite,
    input  logic              id_Branch,
    input  logic              ex_MemRead,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_Branch,
    input  logic              ex_branch_taken,
    output logic              load_use,
    output logic              stall,
    output logic              flush
);

    logic rs2_used;

    always_comb begin
        rs2_used = ~id_ALUSrc | id_MemWrite | id_Branch;
        load_use = ex_MemRead && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (rs2_used && (ex_rd == id_rs2)));
        flush    = ex_Branch & ex_branch_taken;
        // A flushed ID instruction is discarded, so holding it would be pointless
        stall    = load_use & ~flush;
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall, branch flush
// and saturating stall/flush event counters.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        id_ALUOp,
    input  logic              id_Branch,
    input  logic              id_MemRead,
    input  logic              id_MemtoReg,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic              id_Regwrite,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_branch_taken,
    output logic [1:0]        ex_ALUOp,
    output logic              ex_ALUSrc,
    output logic              ex_Branch,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_MemtoReg,
    output logic              ex_Regwrite,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic              mem_MemtoReg,
    output logic              mem_Regwrite,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_MemtoReg,
    output logic              wb_Regwrite,
    output logic [REG_AW-1:0] wb_rd,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CTRL_W-1:0] id_ctrl;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              load_use;

    assign id_ctrl = pack_ctrl(id_ALUOp, id_ALUSrc, id_Branch, id_MemRead,
                               id_MemWrite, id_MemtoReg, id_Regwrite);

    assign ex_ALUOp    = ex_ctrl[ALUOP_MSB:ALUOP_LSB];
    assign ex_ALUSrc   = ex_ctrl[ALUSRC_BIT];
    assign ex_Branch   = ex_ctrl[BRANCH_BIT];
    assign ex_MemRead  = ex_ctrl[MEMREAD_BIT];
    assign ex_MemWrite = ex_ctrl[MEMWRITE_BIT];
    assign ex_MemtoReg = ex_ctrl[MEMTOREG_BIT];
    assign ex_Regwrite = ex_ctrl[REGWRITE_BIT];

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_ALUSrc       (id_ALUSrc),
        .id_MemWrite     (id_MemWrite),
        .id_Branch       (id_Branch),
        .ex_MemRead      (ex_MemRead),
        .ex_rd           (ex_rd),
        .ex_Branch       (ex_Branch),
        .ex_branch_taken (ex_branch_taken),
        .load_use        (load_use),
        .stall           (stall),
        .flush           (flush)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl      <= BUBBLE;
            ex_rd        <= '0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_MemtoReg <= 1'b0;
            mem_Regwrite <= 1'b0;
            mem_rd       <= '0;
            wb_MemtoReg  <= 1'b0;
            wb_Regwrite  <= 1'b0;
            wb_rd        <= '0;
        end else begin
            if (stall || flush) begin
                ex_ctrl <= BUBBLE;
                ex_rd   <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_rd   <= id_rd;
            end
            mem_MemRead  <= ex_ctrl[MEMREAD_BIT];
            mem_MemWrite <= ex_ctrl[MEMWRITE_BIT];
            mem_MemtoReg <= ex_ctrl[MEMTOREG_BIT];
            mem_Regwrite <= ex_ctrl[REGWRITE_BIT];
            mem_rd       <= ex_rd;
            wb_MemtoReg  <= mem_MemtoReg;
            wb_Regwrite  <= mem_Regwrite;
            wb_rd        <= mem_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
            if (flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: a default instance plus a CNT_W=2 instance
// sharing the same stimulus to observe counter saturation.
module tb_ctrl_pipeline;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] rd;
    } bundle_t;

    typedef struct packed {
        bundle_t     ex;
        logic [15:0] scnt;
        logic [15:0] fcnt;
        logic [1:0]  scnt2;
    } exp_t;

    localparam bundle_t BUB = '0;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] id_ALUOp;
    logic id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_Regwrite;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic ex_branch_taken;

    logic [1:0] ex_ALUOp;
    logic ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Regwrite;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_Regwrite;
    logic wb_MemtoReg, wb_Regwrite, stall, flush;
    logic [15:0] stall_cnt, flush_cnt;

    logic [1:0] s_ex_ALUOp;
    logic s_ex_ALUSrc, s_ex_Branch, s_ex_MemRead, s_ex_MemWrite, s_ex_MemtoReg, s_ex_Regwrite;
    logic [4:0] s_ex_rd, s_mem_rd, s_wb_rd;
    logic s_mem_MemRead, s_mem_MemWrite, s_mem_MemtoReg, s_mem_Regwrite;
    logic s_wb_MemtoReg, s_wb_Regwrite, s_stall, s_flush;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic        sb_en = 1'b0;
    exp_t        exq[$];
    bundle_t     memq[$];
    bundle_t     wbq[$];
    bundle_t     model_ex;
    logic [15:0] exp_scnt, exp_fcnt;
    logic [1:0]  exp_scnt2;

    always #5 clk = ~clk;

    ctrl_pipeline dut (
        .clk(clk), .reset(reset),
        .id_ALUOp(id_ALUOp), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
        .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
        .id_Regwrite(id_Regwrite), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken),
        .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg),
        .ex_Regwrite(ex_Regwrite), .ex_rd(ex_rd),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_MemtoReg(mem_MemtoReg),
        .mem_Regwrite(mem_Regwrite), .mem_rd(mem_rd),
        .wb_MemtoReg(wb_MemtoReg), .wb_Regwrite(wb_Regwrite), .wb_rd(wb_rd),
        .stall(stall), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipeline #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .id_ALUOp(id_ALUOp), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
        .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
        .id_Regwrite(id_Regwrite), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken),
        .ex_ALUOp(s_ex_ALUOp), .ex_ALUSrc(s_ex_ALUSrc), .ex_Branch(s_ex_Branch),
        .ex_MemRead(s_ex_MemRead), .ex_MemWrite(s_ex_MemWrite), .ex_MemtoReg(s_ex_MemtoReg),
        .ex_Regwrite(s_ex_Regwrite), .ex_rd(s_ex_rd),
        .mem_MemRead(s_mem_MemRead), .mem_MemWrite(s_mem_MemWrite), .mem_MemtoReg(s_mem_MemtoReg),
        .mem_Regwrite(s_mem_Regwrite), .mem_rd(s_mem_rd),
        .wb_MemtoReg(s_wb_MemtoReg), .wb_Regwrite(s_wb_Regwrite), .wb_rd(s_wb_rd),
        .stall(s_stall), .flush(s_flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Scoreboard: entries pushed before each rising edge are checked on the following falling edge
    always @(negedge clk) begin
        if (sb_en) begin
            exp_t    e;
            bundle_t m, w, got;
            tests++;
            if (exq.size() == 0 || memq.size() == 0 || wbq.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: got empty queue, need an expected entry");
            end else begin
                e   = exq.pop_front();
                m   = memq.pop_front();
                w   = wbq.pop_front();
                got = {ex_ALUOp, ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite,
                       ex_MemtoReg, ex_Regwrite, ex_rd};
                if (got !== e.ex) begin
                    fails++;
                    $display("FAIL ex_stage: got %h, need %h", got, e.ex);
                end
                tests++;
                if ({mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_Regwrite, mem_rd} !==
                    {m.memread, m.memwrite, m.memtoreg, m.regwrite, m.rd}) begin
                    fails++;
                    $display("FAIL mem_stage: got %b, need %b",
                             {mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_Regwrite, mem_rd},
                             {m.memread, m.memwrite, m.memtoreg, m.regwrite, m.rd});
                end
                tests++;
                if ({wb_MemtoReg, wb_Regwrite, wb_rd} !== {w.memtoreg, w.regwrite, w.rd}) begin
                    fails++;
                    $display("FAIL wb_stage: got %b, need %b",
                             {wb_MemtoReg, wb_Regwrite, wb_rd}, {w.memtoreg, w.regwrite, w.rd});
                end
                tests++;
                if (stall_cnt !== e.scnt || flush_cnt !== e.fcnt || s_stall_cnt !== e.scnt2) begin
                    fails++;
                    $display("FAIL counters: got s=%0d f=%0d s2=%0d, need s=%0d f=%0d s2=%0d",
                             stall_cnt, flush_cnt, s_stall_cnt, e.scnt, e.fcnt, e.scnt2);
                end
            end
        end
    end

    task automatic sb_reset();
        exq.delete();
        memq.delete();
        wbq.delete();
        memq.push_back(BUB);
        wbq.push_back(BUB);
        wbq.push_back(BUB);
        model_ex  = BUB;
        exp_scnt  = '0;
        exp_fcnt  = '0;
        exp_scnt2 = '0;
    endtask

    // Called at negedge+1; drives ID, predicts hazards and pushes expectations. Returns at negedge+2.
    task automatic apply(input bundle_t b, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic taken, output logic e_stall, output logic e_flush);
        bundle_t nx;
        logic    rs2_used, lu;
        exp_t    e;
        id_ALUOp = b.aluop;     id_ALUSrc = b.alusrc;     id_Branch = b.branch;
        id_MemRead = b.memread; id_MemWrite = b.memwrite; id_MemtoReg = b.memtoreg;
        id_Regwrite = b.regwrite; id_rd = b.rd; id_rs1 = rs1; id_rs2 = rs2;
        ex_branch_taken = taken;
        rs2_used = ~b.alusrc | b.memwrite | b.branch;
        lu = model_ex.memread && (model_ex.rd != 5'd0) &&
             ((model_ex.rd == rs1) || (rs2_used && (model_ex.rd == rs2)));
        e_flush = model_ex.branch & taken;
        e_stall = lu & ~e_flush;
        nx = b;
        nx.memtoreg = b.memtoreg & b.memread;
        if (e_stall || e_flush) nx = BUB;
        if (e_stall && exp_scnt != 16'hFFFF) exp_scnt++;
        if (e_flush && exp_fcnt != 16'hFFFF) exp_fcnt++;
        if (e_stall && exp_scnt2 != 2'd3) exp_scnt2++;
        e.ex = nx; e.scnt = exp_scnt; e.fcnt = exp_fcnt; e.scnt2 = exp_scnt2;
        exq.push_back(e);
        memq.push_back(nx);
        wbq.push_back(nx);
        model_ex = nx;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic step(input bundle_t b, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic taken);
        logic s, f;
        apply(b, rs1, rs2, taken, s, f);
        tick();
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        reset = 1'b1;
        id_ALUOp = '0; id_ALUSrc = 0; id_Branch = 0; id_MemRead = 0; id_MemWrite = 0;
        id_MemtoReg = 0; id_Regwrite = 0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        ex_branch_taken = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        sb_reset();
        sb_en = 1'b1;
    endtask

    function automatic bundle_t rtype(input logic [4:0] rd);
        bundle_t b = BUB;
        b.aluop = 2'b10; b.regwrite = 1'b1; b.rd = rd;
        return b;
    endfunction

    function automatic bundle_t load(input logic [4:0] rd);
        bundle_t b = BUB;
        b.alusrc = 1'b1; b.memread = 1'b1; b.memtoreg = 1'b1; b.regwrite = 1'b1; b.rd = rd;
        return b;
    endfunction

    task automatic test_rtype();
        bundle_t b;
        logic s, f;
        apply(rtype(5'd7), 5'd1, 5'd2, 1'b0, s, f);
        tick();
        tests++;
        if (ex_ALUOp !== 2'b10 || ex_Regwrite !== 1'b1 || ex_rd !== 5'd7) begin
            fails++;
            $display("FAIL rtype_ex: got op=%b rw=%b rd=%0d, need op=10 rw=1 rd=7",
                     ex_ALUOp, ex_Regwrite, ex_rd);
        end
        b = BUB; b.memtoreg = 1'b1; b.rd = 5'd9;   // MemtoReg without MemRead is dropped
        step(b, 5'd3, 5'd4, 1'b0);
        step(BUB, 5'd0, 5'd0, 1'b0);
        tests++;
        if (wb_Regwrite !== 1'b1 || wb_rd !== 5'd7) begin
            fails++;
            $display("FAIL rtype_wb: got rw=%b rd=%0d, need rw=1 rd=7", wb_Regwrite, wb_rd);
        end
    endtask

    task automatic test_load_use();
        logic s, f;
        logic [15:0] c0;
        c0 = exp_scnt;
        step(load(5'd5), 5'd1, 5'd0, 1'b0);
        apply(rtype(5'd6), 5'd5, 5'd2, 1'b0, s, f);
        tests++;
        if (stall !== 1'b1 || s !== 1'b1) begin
            fails++;
            $display("FAIL load_use_stall: got %b, need 1", stall);
        end
        tick();
        apply(rtype(5'd6), 5'd5, 5'd2, 1'b0, s, f);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL stall_one_cycle: got %b, need 0", stall);
        end
        tick();
        step(rtype(5'd8), 5'd6, 5'd6, 1'b0);
        tests++;
        if (stall_cnt !== c0 + 16'd1) begin
            fails++;
            $display("FAIL stall_cnt_inc: got %0d, need %0d", stall_cnt, c0 + 16'd1);
        end
        // rs2 hazard on a store, which uses rs2 despite ALUSrc
        begin
            bundle_t sw;
            sw = BUB; sw.alusrc = 1'b1; sw.memwrite = 1'b1;
            step(load(5'd12), 5'd0, 5'd0, 1'b0);
            apply(sw, 5'd1, 5'd12, 1'b0, s, f);
            tests++;
            if (stall !== 1'b1) begin
                fails++;
                $display("FAIL store_rs2_stall: got %b, need 1", stall);
            end
            tick();
            step(sw, 5'd1, 5'd12, 1'b0);
        end
    endtask

    task automatic test_no_stall();
        bundle_t addi;
        logic s, f;
        step(load(5'd0), 5'd1, 5'd0, 1'b0);
        apply(rtype(5'd3), 5'd0, 5'd0, 1'b0, s, f);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL x0_no_stall: got %b, need 0", stall);
        end
        tick();
        step(load(5'd5), 5'd1, 5'd0, 1'b0);
        addi = rtype(5'd4); addi.alusrc = 1'b1;
        apply(addi, 5'd1, 5'd5, 1'b0, s, f);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL addi_rs2_no_stall: got %b, need 0", stall);
        end
        tick();
        step(rtype(5'd2), 5'd5, 5'd1, 1'b0);   // EX holds addi now, no hazard
    endtask

    task automatic test_flush_priority();
        bundle_t br;
        logic s, f;
        logic [15:0] sc0, fc0;
        sc0 = exp_scnt; fc0 = exp_fcnt;
        br = BUB; br.branch = 1'b1; br.memread = 1'b1; br.aluop = 2'b01; br.rd = 5'd5;
        step(br, 5'd1, 5'd2, 1'b0);
        apply(rtype(5'd6), 5'd5, 5'd5, 1'b1, s, f);
        tests++;
        if (flush !== 1'b1 || stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_wins: got flush=%b stall=%b, need flush=1 stall=0", flush, stall);
        end
        tick();
        tests++;
        if (ex_Regwrite !== 1'b0 || ex_rd !== 5'd0 || ex_ALUOp !== 2'b00) begin
            fails++;
            $display("FAIL flush_bubble: got rw=%b rd=%0d op=%b, need 0", ex_Regwrite, ex_rd, ex_ALUOp);
        end
        tests++;
        if (flush_cnt !== fc0 + 16'd1 || stall_cnt !== sc0) begin
            fails++;
            $display("FAIL flush_counts: got f=%0d s=%0d, need f=%0d s=%0d",
                     flush_cnt, stall_cnt, fc0 + 16'd1, sc0);
        end
        // not-taken branch leaves ID alone
        step(br, 5'd1, 5'd2, 1'b0);
        apply(rtype(5'd9), 5'd7, 5'd8, 1'b0, s, f);
        tests++;
        if (flush !== 1'b0) begin
            fails++;
            $display("FAIL branch_not_taken: got %b, need 0", flush);
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 4; i++) step(rtype(5'(i + 10)), 5'd1, 5'd2, 1'b0);
        sb_en = 1'b0;
        reset = 1'b1;
        #1;
        tests++;
        if ({ex_ALUOp, ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite, ex_MemtoReg,
             ex_Regwrite, ex_rd, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_Regwrite,
             mem_rd, wb_MemtoReg, wb_Regwrite, wb_rd} !== '0) begin
            fails++;
            $display("FAIL reset_stages: got ex_rd=%0d mem_rd=%0d wb_rd=%0d wb_rw=%b, need all 0",
                     ex_rd, mem_rd, wb_rd, wb_Regwrite);
        end
        tests++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || s_stall_cnt !== '0 || stall !== 1'b0
            || flush !== 1'b0) begin
            fails++;
            $display("FAIL reset_counters: got s=%0d f=%0d s2=%0d st=%b fl=%b, need 0",
                     stall_cnt, flush_cnt, s_stall_cnt, stall, flush);
        end
        do_reset();
    endtask

    task automatic test_saturation();
        logic [1:0] seq [5];
        logic s, f;
        seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(load(5'd5), 5'd1, 5'd0, 1'b0);
            apply(rtype(5'd6), 5'd5, 5'd2, 1'b0, s, f);
            tick();
            tests++;
            if (s_stall_cnt !== seq[i]) begin
                fails++;
                $display("FAIL sat_cnt_%0d: got %0d, need %0d", i, s_stall_cnt, seq[i]);
            end
            step(rtype(5'd6), 5'd5, 5'd2, 1'b0);
        end
        tests++;
        if (stall_cnt !== 16'd5) begin
            fails++;
            $display("FAIL wide_cnt: got %0d, need 5", stall_cnt);
        end
    endtask

    initial begin
        do_reset();
        tests++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || ex_Regwrite !== 1'b0 || wb_rd !== '0) begin
            fails++;
            $display("FAIL test_reset: got s=%0d f=%0d rw=%b wb_rd=%0d, need 0",
                     stall_cnt, flush_cnt, ex_Regwrite, wb_rd);
        end
        test_rtype();
        test_load_use();
        test_no_stall();
        test_flush_priority();
        test_reset_midrun();
        test_saturation();
        repeat (3) step(BUB, 5'd0, 5'd0, 1'b0);
        sb_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
